// File: rtl/mcu_cmd_frame_parser_if.sv
// ----------------------------------------------------------------------------
// mcu_cmd_frame_parser_if
// Bundles the UART-side input and the handler-side outputs of the MCU command
// frame parser.
//   master : the UART side / environment (drives uart_rx_*, observes outputs)
//   slave  : the parser itself
// Signals:
//   uart_rx_byte/uart_rx_valid   byte + one-cycle strobe from the UART receiver
//   para_setting_flag            pulse, valid frame with the parameter-set code
//   other_cmd_flag               pulse, valid frame with any other code
//   ctrl_code                    control code of the last valid frame
//   rx_data/rx_ok                paced replay of the buffered frame
//   parser_busy                  parser is checking, dispatching or replaying
//   frame_drop                   pulse per discarded frame or byte
//   err_cnt                      error counter, only with CMD_PARSER_ERR_CNT_EN
// ----------------------------------------------------------------------------
interface mcu_cmd_frame_parser_if;
  logic [7:0]  uart_rx_byte;
  logic        uart_rx_valid;
  logic        para_setting_flag;
  logic        other_cmd_flag;
  logic [7:0]  ctrl_code;
  logic [7:0]  rx_data;
  logic        rx_ok;
  logic        parser_busy;
  logic        frame_drop;
`ifdef CMD_PARSER_ERR_CNT_EN
  logic [15:0] err_cnt;

  modport master (
    output uart_rx_byte, uart_rx_valid,
    input  para_setting_flag, other_cmd_flag, ctrl_code, rx_data, rx_ok,
           parser_busy, frame_drop, err_cnt
  );
  modport slave (
    input  uart_rx_byte, uart_rx_valid,
    output para_setting_flag, other_cmd_flag, ctrl_code, rx_data, rx_ok,
           parser_busy, frame_drop, err_cnt
  );
`else
  modport master (
    output uart_rx_byte, uart_rx_valid,
    input  para_setting_flag, other_cmd_flag, ctrl_code, rx_data, rx_ok,
           parser_busy, frame_drop
  );
  modport slave (
    input  uart_rx_byte, uart_rx_valid,
    output para_setting_flag, other_cmd_flag, ctrl_code, rx_data, rx_ok,
           parser_busy, frame_drop
  );
`endif
endinterface

// File: rtl/mcu_cmd_frame_parser.sv
// ----------------------------------------------------------------------------
// mcu_cmd_frame_parser
// Hunts for MCU command frames (START CTRL LEN_L LEN_H payload CRC END) in the
// UART byte stream, buffers each frame, checks length / checksum / end code,
// raises a one-cycle handler flag for a good frame and then replays the whole
// buffered frame on a slow rx_data/rx_ok strobe interface.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - mcu_cmd_frame_parser_if.slave (UART input, flags, replay, status)
// Optional feature: define CMD_PARSER_ERR_CNT_EN to add bus.err_cnt, a
// saturating count of frames dropped for length/CRC/end-code/timeout errors.
// BUF_DEPTH must be a power of two and at least MAX_LEN+6.
// ----------------------------------------------------------------------------
module mcu_cmd_frame_parser #(
  parameter logic [7:0] START_CODE    = 8'h68,
  parameter logic [7:0] END_CODE      = 8'h16,
  parameter logic [7:0] PARA_SET_CODE = 8'h01,
  parameter int         MAX_LEN       = 26,
  parameter int         BUF_DEPTH     = 32,
  parameter int         PULSE_W       = 4,
  parameter int         START_GAP     = 4,
  parameter int         TIMEOUT_CYC   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  mcu_cmd_frame_parser_if.slave bus
);
  localparam int AW   = $clog2(BUF_DEPTH);
  localparam int PW   = AW + 1;  // one extra bit so a full buffer is countable
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int CMAX = (START_GAP > 2 * PULSE_W) ? START_GAP : 2 * PULSE_W;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_HUNT, S_CTRL, S_LEN_L, S_LEN_H, S_PAYLOAD, S_CRC, S_END,
    S_CHECK, S_DISPATCH, S_REPLAY
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]     sum_q, sum_d, len_l_q, len_l_d, ctrl_byte_q, ctrl_byte_d;
  logic [15:0]    len_cnt_q, len_cnt_d;
  logic           crc_ok_q, crc_ok_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           streaming_q, streaming_d;
  logic [7:0]     ctrl_code_q, ctrl_code_d;
  logic           para_q, para_d, other_q, other_d;
  logic           rx_ok_q, rx_ok_d, drop_q, drop_d;

  logic [7:0]     buf_mem [BUF_DEPTH];
  logic [7:0]     rd_data_q;
  logic           buf_we;

  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic [15:0]    len_full;
  logic           busy;
  logic           in_frame;

  assign rx_byte  = bus.uart_rx_byte;
  assign rx_valid = bus.uart_rx_valid;
  assign len_full = {rx_byte, len_l_q};
  assign busy     = (state_q == S_CHECK) || (state_q == S_DISPATCH) || (state_q == S_REPLAY);
  assign in_frame = (state_q == S_CTRL) || (state_q == S_LEN_L) || (state_q == S_LEN_H) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CRC) || (state_q == S_END);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sum_d       = sum_q;
    len_l_d     = len_l_q;
    ctrl_byte_d = ctrl_byte_q;
    len_cnt_d   = len_cnt_q;
    crc_ok_d    = crc_ok_q;
    tmo_d       = '0;
    cnt_d       = cnt_q;
    streaming_d = streaming_q;
    ctrl_code_d = ctrl_code_q;
    para_d      = 1'b0;
    other_d     = 1'b0;
    rx_ok_d     = 1'b0;
    drop_d      = 1'b0;
    buf_we      = 1'b0;

    if (in_frame) tmo_d = rx_valid ? '0 : tmo_q + 1'b1;

    case (state_q)
      S_HUNT: if (rx_valid && rx_byte == START_CODE) begin
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1; sum_d = '0; state_d = S_CTRL;
      end
      S_CTRL: if (rx_valid) begin
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1; sum_d = sum_q + rx_byte;
        ctrl_byte_d = rx_byte; state_d = S_LEN_L;
      end
      S_LEN_L: if (rx_valid) begin
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1; sum_d = sum_q + rx_byte;
        len_l_d = rx_byte; state_d = S_LEN_H;
      end
      S_LEN_H: if (rx_valid) begin
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1; sum_d = sum_q + rx_byte;
        if (len_full > 16'(MAX_LEN)) begin
          drop_d = 1'b1; wr_ptr_d = '0; state_d = S_HUNT;
        end else if (len_full == 16'd0) begin
          state_d = S_CRC;
        end else begin
          len_cnt_d = len_full; state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (rx_valid) begin
        // START_CODE bytes in here are plain data; no resync mid-frame.
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1; sum_d = sum_q + rx_byte;
        len_cnt_d = len_cnt_q - 1'b1;
        if (len_cnt_q == 16'd1) state_d = S_CRC;
      end
      S_CRC: if (rx_valid) begin
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1;
        crc_ok_d = (rx_byte == ~sum_q); state_d = S_END;
      end
      S_END: if (rx_valid) begin
        buf_we = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1;
        if (rx_byte == END_CODE && crc_ok_q) begin
          state_d = S_CHECK;
        end else begin
          drop_d = 1'b1; wr_ptr_d = '0; state_d = S_HUNT;
        end
      end
      S_CHECK: begin
        ctrl_code_d = ctrl_byte_q; state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        para_d      = (ctrl_byte_q == PARA_SET_CODE);
        other_d     = (ctrl_byte_q != PARA_SET_CODE);
        rd_ptr_d    = '0;
        cnt_d       = '0;
        streaming_d = 1'b0;
        state_d     = S_REPLAY;
      end
      S_REPLAY: begin
        if (!streaming_q) begin
          // Lead-in gap after the flag; the RAM read of byte 0 happens here.
          if (cnt_q == CW'(START_GAP - 1)) begin
            streaming_d = 1'b1; cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Per-byte slot of 2*PULSE_W cycles: rx_ok high for the first half.
          // rd_ptr advances two cycles before the slot ends so that the
          // registered RAM read presents the next byte one cycle ahead of
          // its rx_ok rise.
          rx_ok_d = (cnt_q < CW'(PULSE_W));
          if (cnt_q == CW'(2 * PULSE_W - 2)) rd_ptr_d = rd_ptr_q + 1'b1;
          if (cnt_q == CW'(2 * PULSE_W - 1)) begin
            cnt_d = '0;
            if (rd_ptr_q == wr_ptr_q) begin
              wr_ptr_d = '0; state_d = S_HUNT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Inter-byte timeout beats whatever the byte handling above decided.
    if (in_frame && tmo_q == TW'(TIMEOUT_CYC)) begin
      state_d = S_HUNT; wr_ptr_d = '0; drop_d = 1'b1; buf_we = 1'b0; tmo_d = '0;
    end

    // Bytes arriving while busy are discarded without touching the replay.
    if (busy && rx_valid) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;       wr_ptr_q <= '0;      rd_ptr_q <= '0;
      sum_q <= '0;             len_l_q <= '0;       ctrl_byte_q <= '0;
      len_cnt_q <= '0;         crc_ok_q <= 1'b0;    tmo_q <= '0;
      cnt_q <= '0;             streaming_q <= 1'b0; ctrl_code_q <= '0;
      para_q <= 1'b0;          other_q <= 1'b0;     rx_ok_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;      wr_ptr_q <= wr_ptr_d;   rd_ptr_q <= rd_ptr_d;
      sum_q <= sum_d;          len_l_q <= len_l_d;     ctrl_byte_q <= ctrl_byte_d;
      len_cnt_q <= len_cnt_d;  crc_ok_q <= crc_ok_d;   tmo_q <= tmo_d;
      cnt_q <= cnt_d;          streaming_q <= streaming_d; ctrl_code_q <= ctrl_code_d;
      para_q <= para_d;        other_q <= other_d;     rx_ok_q <= rx_ok_d;
      drop_q <= drop_d;
    end
  end

  // Frame buffer: plain write port, registered read port.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr_q[AW-1:0]] <= rx_byte;
  end

  // Read only while a buffered byte is due, so rx_data holds the last
  // replayed byte afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (state_q == S_REPLAY && rd_ptr_q < wr_ptr_q) begin
      rd_data_q <= buf_mem[rd_ptr_q[AW-1:0]];
    end
  end

`ifdef CMD_PARSER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Error drops only happen outside the busy states, busy drops only inside.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop_d && !busy && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.para_setting_flag = para_q;
  assign bus.other_cmd_flag    = other_q;
  assign bus.ctrl_code         = ctrl_code_q;
  assign bus.rx_data           = rd_data_q;
  assign bus.rx_ok             = rx_ok_q;
  assign bus.parser_busy       = busy;
  assign bus.frame_drop        = drop_q;
endmodule

// File: tb/tb_mcu_cmd_frame_parser.sv
module tb_mcu_cmd_frame_parser;
  localparam int START_GAP   = 4;
  localparam int PULSE_W     = 4;
  localparam int TIMEOUT_CYC = 50000;
  localparam int NV          = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcu_cmd_frame_parser_if bus ();

  mcu_cmd_frame_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [0:35][7:0] frame;
    int               n;
    int               skip;
    int               exp_para;
    int               exp_other;
    int               exp_drop;
    logic [7:0]       exp_ctrl;
    int               exp_rises;
  } vec_t;

  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  // ---------------- monitor (sampled on the falling edge) ----------------
  int         cyc = 0;
  int         para_seen = 0, other_seen = 0, drop_seen = 0, setup_bad = 0;
  int         flag_cyc = 0;
  int         rise_cyc [$];
  logic [7:0] rise_data [$];
  logic       prev_ok = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.para_setting_flag) begin para_seen++; flag_cyc = cyc; end
    if (bus.other_cmd_flag)    begin other_seen++; flag_cyc = cyc; end
    if (bus.frame_drop) drop_seen++;
    if (bus.rx_ok && !prev_ok) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(bus.rx_data);
      if (bus.rx_data !== prev_data) setup_bad++;
    end
    prev_ok   = bus.rx_ok;
    prev_data = bus.rx_data;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic ld(input int v, input logic [7:0] b);
    vecs[v].frame[vecs[v].n] = b;
    vecs[v].n++;
  endtask

  task automatic ex(input int v, input int p, input int o, input int d,
                    input logic [7:0] c, input int r, input int s);
    vecs[v].exp_para = p; vecs[v].exp_other = o; vecs[v].exp_drop = d;
    vecs[v].exp_ctrl = c; vecs[v].exp_rises = r; vecs[v].skip = s;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.uart_rx_byte  = b;
    bus.uart_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.uart_rx_valid = 1'b0;
  endtask

  task automatic send_vec(input int v);
    for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].frame[i]);
  endtask

  task automatic wait_idle(input string name);
    int k;
    repeat (4) @(posedge clk);
    k = 0;
    while (bus.parser_busy && k < 2000) begin @(posedge clk); k++; end
    if (bus.parser_busy) check({name, "_idle_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
  endtask

  // Compares replayed bytes / timing since rise index b0 against vector v.
  task automatic check_replay(input string name, input int v, input int b0, input int nrise);
    int bad, sbad;
    check({name, "_rises"}, nrise, vecs[v].exp_rises);
    if (nrise > 0 && nrise == vecs[v].exp_rises) begin
      bad = 0;
      for (int i = 0; i < nrise; i++)
        if (rise_data[b0 + i] !== vecs[v].frame[vecs[v].skip + i]) bad++;
      check({name, "_data_mismatches"}, bad, 0);
      check({name, "_first_rise_delay"}, rise_cyc[b0] - flag_cyc, START_GAP + 1);
      sbad = 0;
      for (int i = 1; i < nrise; i++)
        if (rise_cyc[b0 + i] - rise_cyc[b0 + i - 1] != 2 * PULSE_W) sbad++;
      check({name, "_spacing_errors"}, sbad, 0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int pb, ob, db, rb, sb, k;
`ifdef CMD_PARSER_ERR_CNT_EN
    int eb;
`endif
    string nm;

    // ---- vector table ----
    for (int v = 0; v < NV; v++) vecs[v] = '0;
    // v0: para frame, LEN 22 zeros, CRC ~(01+16)=E8
    ld(0, 8'h68); ld(0, 8'h01); ld(0, 8'h16); ld(0, 8'h00);
    for (int i = 0; i < 22; i++) ld(0, 8'h00);
    ld(0, 8'hE8); ld(0, 8'h16);
    ex(0, 1, 0, 0, 8'h01, 28, 0);
    // v1: same frame, bad CRC
    ld(1, 8'h68); ld(1, 8'h01); ld(1, 8'h16); ld(1, 8'h00);
    for (int i = 0; i < 22; i++) ld(1, 8'h00);
    ld(1, 8'hE9); ld(1, 8'h16);
    ex(1, 0, 0, 1, 8'h01, 0, 0);
    // v2: ctrl 05, LEN 0
    ld(2, 8'h68); ld(2, 8'h05); ld(2, 8'h00); ld(2, 8'h00); ld(2, 8'hFA); ld(2, 8'h16);
    ex(2, 0, 1, 0, 8'h05, 6, 0);
    // v3: LEN 27 -> dropped at LEN_H
    ld(3, 8'h68); ld(3, 8'h01); ld(3, 8'h1B); ld(3, 8'h00);
    ex(3, 0, 0, 1, 8'h05, 0, 0);
    // v4: start code inside payload is data; CRC ~(02+02+68+AA)=E9
    ld(4, 8'h68); ld(4, 8'h02); ld(4, 8'h02); ld(4, 8'h00);
    ld(4, 8'h68); ld(4, 8'hAA); ld(4, 8'hE9); ld(4, 8'h16);
    ex(4, 0, 1, 0, 8'h02, 8, 0);
    // v5: junk before START is ignored without drop
    ld(5, 8'h11); ld(5, 8'h22);
    ld(5, 8'h68); ld(5, 8'h01); ld(5, 8'h00); ld(5, 8'h00); ld(5, 8'hFE); ld(5, 8'h16);
    ex(5, 1, 0, 0, 8'h01, 6, 2);
    // v6: wrong end code
    ld(6, 8'h68); ld(6, 8'h03); ld(6, 8'h00); ld(6, 8'h00); ld(6, 8'hFC); ld(6, 8'h17);
    ex(6, 0, 0, 1, 8'h01, 0, 0);
    // v7: LEN 256 (high byte set) -> dropped
    ld(7, 8'h68); ld(7, 8'h01); ld(7, 8'h00); ld(7, 8'h01);
    ex(7, 0, 0, 1, 8'h01, 0, 0);
    // v8: LEN = MAX_LEN = 26, payload 00..19, CRC ~(07+1A+45)=99, fills buffer
    ld(8, 8'h68); ld(8, 8'h07); ld(8, 8'h1A); ld(8, 8'h00);
    for (int i = 0; i < 26; i++) ld(8, 8'(i));
    ld(8, 8'h99); ld(8, 8'h16);
    ex(8, 0, 1, 0, 8'h07, 32, 0);

    // ---- reset ----
    bus.uart_rx_byte  = 8'h00;
    bus.uart_rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_para_flag", int'(bus.para_setting_flag), 0);
    check("reset_other_flag", int'(bus.other_cmd_flag), 0);
    check("reset_ctrl_code", int'(bus.ctrl_code), 0);
    check("reset_rx_data", int'(bus.rx_data), 0);
    check("reset_rx_ok", int'(bus.rx_ok), 0);
    check("reset_busy", int'(bus.parser_busy), 0);
    check("reset_frame_drop", int'(bus.frame_drop), 0);
`ifdef CMD_PARSER_ERR_CNT_EN
    check("reset_err_cnt", int'(bus.err_cnt), 0);
`endif

    // ---- table-driven vectors ----
    for (int v = 0; v < NV; v++) begin
      pb = para_seen; ob = other_seen; db = drop_seen; rb = rise_cyc.size(); sb = setup_bad;
`ifdef CMD_PARSER_ERR_CNT_EN
      eb = int'(bus.err_cnt);
`endif
      nm = $sformatf("vec%0d", v);
      send_vec(v);
      wait_idle(nm);
      check({nm, "_para_pulses"}, para_seen - pb, vecs[v].exp_para);
      check({nm, "_other_pulses"}, other_seen - ob, vecs[v].exp_other);
      check({nm, "_drops"}, drop_seen - db, vecs[v].exp_drop);
      check({nm, "_ctrl_code"}, int'(bus.ctrl_code), int'(vecs[v].exp_ctrl));
      check_replay(nm, v, rb, rise_cyc.size() - rb);
      check({nm, "_data_setup_errors"}, setup_bad - sb, 0);
`ifdef CMD_PARSER_ERR_CNT_EN
      check({nm, "_err_cnt_delta"}, int'(bus.err_cnt) - eb, vecs[v].exp_drop);
`endif
      $display("[TB] %s: %0d bytes sent, para=%0d other=%0d drops=%0d rises=%0d ctrl=%02h",
               nm, vecs[v].n, para_seen - pb, other_seen - ob, drop_seen - db,
               rise_cyc.size() - rb, bus.ctrl_code);
    end

    // ---- inter-byte timeout ----
    db = drop_seen;
`ifdef CMD_PARSER_ERR_CNT_EN
    eb = int'(bus.err_cnt);
`endif
    send_byte(8'h68);
    send_byte(8'h01);
    repeat (TIMEOUT_CYC - 20) @(posedge clk);
    check("timeout_no_early_drop", drop_seen - db, 0);
    repeat (40) @(posedge clk);
    check("timeout_drop", drop_seen - db, 1);
`ifdef CMD_PARSER_ERR_CNT_EN
    check("timeout_err_cnt_delta", int'(bus.err_cnt) - eb, 1);
`endif
    pb = para_seen; rb = rise_cyc.size();
    send_vec(5);
    wait_idle("after_timeout");
    check("after_timeout_para", para_seen - pb, 1);
    check_replay("after_timeout", 5, rb, rise_cyc.size() - rb);
    $display("[TB] timeout: drops=%0d, following frame para=%0d", drop_seen - db, para_seen - pb);

    // ---- bytes injected during replay ----
    ob = other_seen; db = drop_seen; rb = rise_cyc.size();
`ifdef CMD_PARSER_ERR_CNT_EN
    eb = int'(bus.err_cnt);
`endif
    send_vec(2);
    k = 0;
    while (other_seen == ob && k < 100) begin @(posedge clk); k++; end
    check("inject_flag_seen", other_seen - ob, 1);
    send_byte(8'h68);
    repeat (8) @(posedge clk);
    send_byte(8'h55);
    repeat (8) @(posedge clk);
    send_byte(8'h16);
    wait_idle("inject");
    check("inject_drops", drop_seen - db, 3);
    check_replay("inject", 2, rb, rise_cyc.size() - rb);
`ifdef CMD_PARSER_ERR_CNT_EN
    check("inject_err_cnt_delta", int'(bus.err_cnt) - eb, 0);
`endif
    $display("[TB] inject: drops=%0d rises=%0d", drop_seen - db, rise_cyc.size() - rb);

    // ---- reset in the middle of a replay ----
    send_vec(0);
    k = 0;
    while (!bus.rx_ok && k < 200) begin @(negedge clk); k++; end
    check("midreplay_rx_ok_seen", int'(bus.rx_ok), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rx_ok", int'(bus.rx_ok), 0);
    check("rst_mid_rx_data", int'(bus.rx_data), 0);
    check("rst_mid_busy", int'(bus.parser_busy), 0);
    check("rst_mid_ctrl_code", int'(bus.ctrl_code), 0);
    check("rst_mid_flags", int'(bus.para_setting_flag) + int'(bus.other_cmd_flag), 0);
    check("rst_mid_frame_drop", int'(bus.frame_drop), 0);
`ifdef CMD_PARSER_ERR_CNT_EN
    check("rst_mid_err_cnt", int'(bus.err_cnt), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    ob = other_seen; rb = rise_cyc.size();
    send_vec(2);
    wait_idle("after_rst");
    check("after_rst_other", other_seen - ob, 1);
    check("after_rst_ctrl_code", int'(bus.ctrl_code), 5);
    check_replay("after_rst", 2, rb, rise_cyc.size() - rb);
    $display("[TB] reset mid-replay: recovered, other=%0d rises=%0d", other_seen - ob, rise_cyc.size() - rb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
